// File: rtl/risc16_pkg.sv
// Shared constants and loader state type for the 16-bit instruction memory.
// The CHK state exists only when IMEM_LOADER_CHECKSUM_EN is defined.
package risc16_pkg;

  localparam int unsigned INSTR_W     = 16;
  localparam int unsigned IMEM_DEPTH  = 15;
  localparam int unsigned IMEM_ADDR_W = 4;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_LEN,
    LD_HI,
    LD_LO,
    LD_WRITE,
    LD_DONE,
    LD_ERR
`ifdef IMEM_LOADER_CHECKSUM_EN
    , LD_CHK
`endif
  } loader_state_t;

endpackage

// File: rtl/imem_loader.sv
// Streams host bytes (length, then big-endian words) into the instruction memory and
// holds the CPU until the program is complete. Optional trailer check: IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import risc16_pkg::*;
#(
  parameter int unsigned DATA_W = INSTR_W,
  parameter int unsigned ADDR_W = IMEM_ADDR_W,
  parameter int unsigned DEPTH  = IMEM_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam logic [7:0] DEPTH_B = 8'(DEPTH);

  loader_state_t     state;
  logic [ADDR_W-1:0] last_addr;
  logic              xfer;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  assign xfer = byte_valid && byte_ready;

  // mem_addr doubles as the word counter; it only advances when leaving WRITE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LD_IDLE;
      byte_ready <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      last_addr  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      case (state)
        LD_IDLE, LD_DONE, LD_ERR: begin
          if (start) begin
            state      <= LD_LEN;
            byte_ready <= 1'b1;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            mem_addr   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
          end
        end
        LD_LEN: begin
          if (xfer) begin
            last_addr <= ADDR_W'(byte_in - 8'd1);
            if (byte_in == 8'd0 || byte_in > DEPTH_B) begin
              state      <= LD_ERR;
              byte_ready <= 1'b0;
              error      <= 1'b1;
            end else begin
              state <= LD_HI;
            end
          end
        end
        LD_HI: begin
          if (xfer) begin
            mem_wdata[DATA_W-1 -: 8] <= byte_in;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum <= csum ^ byte_in;
`endif
            state <= LD_LO;
          end
        end
        LD_LO: begin
          if (xfer) begin
            mem_wdata[7:0] <= byte_in;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum <= csum ^ byte_in;
`endif
            state      <= LD_WRITE;
            byte_ready <= 1'b0;
            mem_we     <= 1'b1;
          end
        end
        LD_WRITE: begin
          if (mem_addr == last_addr) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state      <= LD_CHK;
            byte_ready <= 1'b1;
`else
            state    <= LD_DONE;
            done     <= 1'b1;
            cpu_hold <= 1'b0;
`endif
          end else begin
            mem_addr   <= mem_addr + ADDR_W'(1);
            state      <= LD_HI;
            byte_ready <= 1'b1;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        LD_CHK: begin
          if (xfer) begin
            byte_ready <= 1'b0;
            if (byte_in == csum) begin
              state    <= LD_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= LD_ERR;
              error <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state      <= LD_IDLE;
          byte_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
